pipe_hazard_ctl: RTL and testbench
==================================

// Module: pipe_hazard_ctl
// PURPOSE
//   Parametrised hazard and pipeline-control unit for the 5-stage MIPS-Lite pipeline.
//   Tracks in-flight register writers in a scoreboard and raises stall for RAW hazards
//   (load-use only when forwarding is compiled in).
//   Raises flush on taken branches resolved DEPTH-configurable stages downstream, and on jumps.
//   Sits beside control_single in ID; drives PC/IF_ID enables and IF_ID/ID_EX bubble insertion.
// PARAMETERS
//   REG_AW    5   register-number width (2**REG_AW architectural registers; reg 0 never hazards)
//   DEPTH     3   scoreboard entries = stages after ID that hold a pending write (EX, MEM, WB)
//   BR_STAGE  2   entry index+1 where branch resolves (2 = EX/MEM, matches PCSrc timing); 1..DEPTH
//   CNT_W     16  width of performance counters
// PORTS
//   clk           in   1       rising-edge clock
//   rst           in   1       synchronous, active-high reset
//   id_valid      in   1       ID holds a real instruction
//   id_rs         in   REG_AW  source register 1
//   id_rt         in   REG_AW  source register 2
//   id_use_rs     in   1       instruction reads rs
//   id_use_rt     in   1       instruction reads rt
//   id_wr_en      in   1       instruction writes register file (RegWrite)
//   id_wn         in   REG_AW  destination register (post-RegDst)
//   id_is_load    in   1       instruction is a load (MemRead)
//   id_jump       in   1       Jump/JumpR decoded in ID
//   br_taken      in   1       Branch&Zero at resolution stage BR_STAGE
//   stall         out  1       hold PC and IF_ID; insert bubble into ID_EX
//   flush_if_id   out  1       zero IF_ID on next edge
//   flush_id_ex   out  1       zero ID_EX on next edge
//   stall_cnt     out  CNT_W   cycles with stall=1 (saturating)
//   flush_cnt     out  CNT_W   taken-branch + jump redirect events (saturating)
// BEHAVIOUR
//   Scoreboard: DEPTH entries {v, wr, wn, ld}; entry 0 = EX, entry DEPTH-1 = WB.
//   Every edge entries shift k->k+1; oldest drops out. Entry 0 loads ID instr if
//   id_valid & !stall & !flush_id_ex, else a bubble (v=0).
//   Match(k) = v & wr & wn!=0 & ((id_use_rs & wn==id_rs) | (id_use_rt & wn==id_rt)).
//   stall (comb.) = id_valid & !br_taken & hazard; hazard defined under CONFIGURATION.
//   br_taken: flush_if_id=1, flush_id_ex=1, entries 0..BR_STAGE-2 cleared (v=0) on the same
//     edge as the shift; stall forced 0 that cycle. Branch penalty = BR_STAGE+1 cycles.
//   id_jump & id_valid & !stall & !br_taken: flush_if_id=1 only (one-cycle bubble).
//   Jump with stall=1: flush deferred until stall drops; jump never lost.
//   Priority: br_taken > stall > jump.
//   Counters increment by 1 per qualifying cycle; hold at 2**CNT_W-1; flush_cnt counts
//     br_taken and accepted jumps (simultaneous: +1 only).
//   Reset: scoreboard all v=0, counters 0; stall, flush_if_id, flush_id_ex forced 0 while
//     rst=1. First cycle after reset: no hazard possible (empty scoreboard).
//   Reset mid-stall: stall drops in the reset cycle; pending hazards are discarded.
// CONFIGURATION
//   Macro PIPE_HAZARD_FWD_EN:
//   defined:   forwarding unit present; hazard = Match(0) & entry0.ld
//              (load-use only, exactly 1 stall cycle per load-use pair).
//   undefined: no forwarding; hazard = OR of Match(k), k=0..DEPTH-1
//              (register file written at edge, read comb. in ID, so WB entry still hazards;
//              stall up to DEPTH cycles).
// TESTING
//   no FWD: add $3,$1,$2 then add $4,$3,$3 -> stall=1 for 3 cycles, stall_cnt=3, second add enters EX 4th cycle.
//   FWD_EN: lw $5,0($0) then add $6,$5,$1 -> stall=1 exactly 1 cycle; add $7,$6,$1 after add -> stall=0.
//   Writer to $0 (id_wn=0, wr=1) followed by reader of $0 -> stall=0 in both configurations.
//   br_taken=1 with load-use hazard pending in ID -> stall=0, flush_if_id=flush_id_ex=1, entries 0..BR_STAGE-2 cleared, flush_cnt+1.
//   id_jump while stalled 2 cycles -> flush_if_id=1 in first cycle stall=0, flush_cnt=1.
//   rst=1 during active stall -> all outputs 0 next cycle; counters 0; CNT_W=4 saturation: 20 stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/pipe_hazard_if.sv
`default_nettype none
// ============================================================================
// pipe_hazard_if : ID-stage hazard/pipeline-control bundle for pipe_hazard_ctl
// Rev 1.0
// ============================================================================
interface pipe_hazard_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_wr_en;
  logic [REG_AW-1:0] id_wn;
  logic              id_is_load;
  logic              id_jump;
  logic              br_taken;
  logic              stall;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wn,
           id_is_load, id_jump, br_taken,
    input  stall, flush_if_id, flush_id_ex, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wn,
           id_is_load, id_jump, br_taken,
    output stall, flush_if_id, flush_id_ex, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctl : scoreboard-based RAW stall / branch-jump flush control.
// Optional load-use-only stalling with forwarding: define PIPE_HAZARD_FWD_EN.
// Rev 1.0
// ============================================================================
module pipe_hazard_ctl #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int BR_STAGE = 2,
  parameter int CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  pipe_hazard_if.slave  bus
);

  typedef struct packed {
    logic              v;
    logic              wr;
    logic              ld;
    logic [REG_AW-1:0] wn;
  } sb_entry_t;

  sb_entry_t        sb_q [DEPTH];
  sb_entry_t        sb_d [DEPTH];
  logic [DEPTH-1:0] match_w;
  logic             hazard_w;
  logic             stall_w;
  logic             flush_if_id_w;
  logic             flush_id_ex_w;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             unused_w;

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_match
      assign match_w[k] = sb_q[k].v & sb_q[k].wr & (sb_q[k].wn != '0) &
                          ((bus.id_use_rs & (sb_q[k].wn == bus.id_rs)) |
                           (bus.id_use_rt & (sb_q[k].wn == bus.id_rt)));
    end
  endgenerate

`ifdef PIPE_HAZARD_FWD_EN
  assign hazard_w = match_w[0] & sb_q[0].ld;
`else
  assign hazard_w = |match_w;
`endif

  assign unused_w = ^{match_w, sb_q[DEPTH-1]};

  assign stall_w       = ~rst & bus.id_valid & ~bus.br_taken & hazard_w;
  assign flush_id_ex_w = ~rst & bus.br_taken;
  // A jump held in ID by a stall keeps id_jump asserted, so it fires once the stall clears.
  assign flush_if_id_w = ~rst & (bus.br_taken | (bus.id_jump & bus.id_valid & ~stall_w));

  assign bus.stall       = stall_w;
  assign bus.flush_if_id = flush_if_id_w;
  assign bus.flush_id_ex = flush_id_ex_w;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

  always_comb begin
    sb_d[0] = '0;
    if (bus.id_valid & ~stall_w & ~bus.br_taken) begin
      sb_d[0] = '{v: 1'b1, wr: bus.id_wr_en, ld: bus.id_is_load, wn: bus.id_wn};
    end
    for (int k = 1; k < DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
      // Entries younger than the resolving branch are wrong-path and get squashed as they advance.
      if (bus.br_taken && (k < BR_STAGE)) begin
        sb_d[k].v = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        sb_q[k] <= '0;
      end
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        sb_q[k] <= sb_d[k];
      end
      if (stall_w && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_if_id_w && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctl.sv
`default_nettype none
// Testbench for pipe_hazard_ctl: directed scenarios plus randomized traffic vs. a queue model.
module tb_pipe_hazard_ctl;
  localparam int REG_AW   = 5;
  localparam int DEPTH    = 3;
  localparam int BR_STAGE = 2;
  localparam int CNT_W    = 4;
  localparam int CMAX     = (1 << CNT_W) - 1;
`ifdef PIPE_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  pipe_hazard_ctl #(.REG_AW(REG_AW), .DEPTH(DEPTH), .BR_STAGE(BR_STAGE), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit v;
    bit wr;
    bit ld;
    int wn;
  } ent_t;

  int   vectors     = 0;
  int   miscompares = 0;
  ent_t sb[$];
  int   m_scnt = 0;
  int   m_fcnt = 0;
  bit   m_stall = 1'b0;
  bit   m_fif   = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit hit(ent_t e, int rs, int rt, bit urs, bit urt);
    return e.v && e.wr && (e.wn != 0) && ((urs && e.wn == rs) || (urt && e.wn == rt));
  endfunction

  task automatic model_clear();
    ent_t b;
    b = '{v: 1'b0, wr: 1'b0, ld: 1'b0, wn: 0};
    sb = {};
    repeat (DEPTH) sb.push_back(b);
    m_scnt = 0;
    m_fcnt = 0;
  endtask

  // One clock cycle: drive ID inputs, check outputs mid-cycle, then advance the model across the edge.
  task automatic step(input bit r, input bit v, input int rs, input int rt, input bit urs,
                      input bit urt, input bit wr, input int wn, input bit ld, input bit jmp,
                      input bit br);
    bit   haz;
    ent_t n;
    rst            = r;
    bus.id_valid   = v;
    bus.id_rs      = REG_AW'(rs);
    bus.id_rt      = REG_AW'(rt);
    bus.id_use_rs  = urs;
    bus.id_use_rt  = urt;
    bus.id_wr_en   = wr;
    bus.id_wn      = REG_AW'(wn);
    bus.id_is_load = ld;
    bus.id_jump    = jmp;
    bus.br_taken   = br;
    @(negedge clk);
    haz = 1'b0;
    if (FWD) begin
      haz = hit(sb[0], rs, rt, urs, urt) && sb[0].ld;
    end else begin
      foreach (sb[k]) if (hit(sb[k], rs, rt, urs, urt)) haz = 1'b1;
    end
    m_stall = !r && v && !br && haz;
    m_fif   = !r && (br || (jmp && v && !m_stall));
    chk_eq("stall", bus.stall, m_stall);
    chk_eq("flush_if_id", bus.flush_if_id, m_fif);
    chk_eq("flush_id_ex", bus.flush_id_ex, !r && br);
    chk_eq("stall_cnt", bus.stall_cnt, m_scnt);
    chk_eq("flush_cnt", bus.flush_cnt, m_fcnt);
    @(posedge clk);
    if (r) begin
      model_clear();
    end else begin
      if (m_stall && m_scnt < CMAX) m_scnt++;
      if (m_fif && m_fcnt < CMAX) m_fcnt++;
      if (br) for (int k = 0; k < BR_STAGE - 1; k++) sb[k].v = 1'b0;
      void'(sb.pop_back());
      n = '{v: v && !m_stall && !br, wr: wr, ld: ld, wn: wn};
      sb.push_front(n);
    end
    #1;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  bit hv, hurs, hurt, hwr, hld, hjmp;
  int hrs, hrt, hwn;

  initial begin
    bus.id_valid = 0; bus.id_rs = '0; bus.id_rt = '0; bus.id_use_rs = 0; bus.id_use_rt = 0;
    bus.id_wr_en = 0; bus.id_wn = '0; bus.id_is_load = 0; bus.id_jump = 0; bus.br_taken = 0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    do_reset();

    // RAW pair: writer of $3 (a load when forwarding exists) followed by a reader of $3
    step(0, 1, 1, 2, 1, 1, 1, 3, FWD, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 3, 3, 1, 1, 1, 4, 0, 0, 0);
      if (!m_stall) break;
    end
    chk_eq("raw_stall_cnt", bus.stall_cnt, FWD ? 1 : 3);
    step(0, 1, 4, 1, 1, 1, 1, 7, 0, 0, 0);

    // Writes to $0 never create a hazard
    do_reset();
    step(0, 1, 1, 2, 1, 1, 1, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 1, 1, 6, 0, 0, 0);
    chk_eq("zero_reg_stall_cnt", bus.stall_cnt, 0);

    // Jump held in ID during a stall redirects exactly once
    do_reset();
    step(0, 1, 0, 0, 0, 0, 1, 3, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 3, 0, 1, 0, 0, 0, 0, 1, 0);
      if (m_fif) break;
    end
    chk_eq("jump_flush_cnt", bus.flush_cnt, 1);

    // Taken branch overrides a pending load-use stall
    do_reset();
    step(0, 1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
    step(0, 1, 5, 1, 1, 1, 1, 6, 0, 0, 1);
    chk_eq("branch_flush_cnt", bus.flush_cnt, 1);
    chk_eq("branch_stall_cnt", bus.stall_cnt, 0);
    step(0, 1, 5, 1, 1, 1, 1, 6, 0, 0, 0);

    // Reset during an active stall
    do_reset();
    step(0, 1, 0, 0, 0, 0, 1, 2, 1, 0, 0);
    step(0, 1, 2, 2, 1, 1, 1, 4, 0, 0, 0);
    step(1, 1, 2, 2, 1, 1, 1, 4, 0, 0, 0);
    chk_eq("rst_stall_cnt", bus.stall_cnt, 0);
    step(0, 1, 2, 2, 1, 1, 1, 4, 0, 0, 0);

    // Counter saturation over many load-use pairs
    do_reset();
    for (int p = 0; p < 20; p++) begin
      step(0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
      for (int i = 0; i < 8; i++) begin
        step(0, 1, 1, 1, 1, 1, 1, 2, 0, 0, 0);
        if (!m_stall) break;
      end
    end
    chk_eq("sat_stall_cnt", bus.stall_cnt, CMAX);

    // Randomized traffic; a stalled ID instruction is held, as the real pipeline does
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (!m_stall) begin
        hv   = ($urandom_range(0, 7) != 0);
        hrs  = $urandom_range(0, 3);
        hrt  = $urandom_range(0, 3);
        hurs = $urandom_range(0, 1);
        hurt = $urandom_range(0, 1);
        hwr  = ($urandom_range(0, 3) != 0);
        hwn  = $urandom_range(0, 3);
        hld  = ($urandom_range(0, 2) == 0);
        hjmp = ($urandom_range(0, 5) == 0);
      end
      step(($urandom_range(0, 49) == 0), hv, hrs, hrt, hurs, hurt, hwr, hwn, hld, hjmp,
           ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
